// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_seq_state_t;

    localparam int LOSS_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, resets to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_seq.sv
// PLL power-up/recovery sequencer: reset pulse, lock wait with timeout and
// retries, lock stability qualification, then downstream reset release.
module pll_lock_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 3,
    localparam int RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  force_reset,
    output logic                  pll_resetb,
    output logic                  rst_out,
    output logic                  ready,
    output logic                  fail,
    output logic [RETRY_W-1:0]    retry_cnt,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY);

    pll_seq_state_t          state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [RETRY_W-1:0]      retry_nxt;
    logic [LOSS_CNT_W-1:0]   loss_nxt;
    logic                    lock_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // A lock drop in STABLE is checked before the stable-count expiry so a
    // glitch on the final count still falls back to WAIT_LOCK.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        loss_nxt  = loss_cnt;
        if (force_reset) begin
            state_nxt = PLL_RST;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt_nxt = '0;
                        if (retry_cnt == RETRY_LAST) begin
                            state_nxt = FAIL;
                        end else begin
                            state_nxt = PLL_RST;
                            retry_nxt = retry_cnt + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_nxt = PLL_RST;
                        cnt_nxt   = '0;
                        retry_nxt = '0;
                        if (loss_cnt != '1) begin
                            loss_nxt = loss_cnt + 1'b1;
                        end
                    end
                end
                FAIL: begin
                end
                default: begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they switch on the same edge as it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PLL_RST;
            cnt        <= '0;
            retry_cnt  <= '0;
            loss_cnt   <= '0;
            pll_resetb <= 1'b0;
            rst_out    <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            retry_cnt  <= retry_nxt;
            loss_cnt   <= loss_nxt;
            pll_resetb <= !(state_nxt == PLL_RST || state_nxt == FAIL);
            rst_out    <= (state_nxt != RUN);
            ready      <= (state_nxt == RUN);
            fail       <= (state_nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed testbench for pll_lock_seq with small parameters.
module tb_pll_lock_seq;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       force_reset;
    logic       pll_resetb;
    logic       rst_out;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [3:0] status;

    int n_checks = 0;
    int n_pass   = 0;

    assign status = {pll_resetb, rst_out, ready, fail};

    pll_lock_seq #(
        .RST_CYCLES   (4),
        .LOCK_STABLE  (8),
        .LOCK_TIMEOUT (32),
        .MAX_RETRY    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .force_reset (force_reset),
        .pll_resetb  (pll_resetb),
        .rst_out     (rst_out),
        .ready       (ready),
        .fail        (fail),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // status = {pll_resetb, rst_out, ready, fail}:
    //   PLL_RST 0100, WAIT_LOCK/STABLE 1100, RUN 1010, FAIL 0101
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b0; force_reset = 1'b0;
        tick(2);
        n_checks++;
        if (status !== 4'b0100) $display("[TB] FAIL reset_status got %b want 0100", status); else n_pass++;
        n_checks++;
        if (retry_cnt !== 2'd0 || loss_cnt !== 8'd0) $display("[TB] FAIL reset_counts got retry=%0d loss=%0d want 0/0", retry_cnt, loss_cnt); else n_pass++;
        rst = 1'b0;
        tick(3);
        n_checks++;
        if (pll_resetb !== 1'b0) $display("[TB] FAIL rst_hold_edge3 got pll_resetb=%b want 0", pll_resetb); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b1100) $display("[TB] FAIL rst_release_edge4 got %b want 1100", status); else n_pass++;
    endtask

    task automatic test_nominal();
        tick(6);
        pll_locked = 1'b1;
        tick(10);
        n_checks++;
        if (status !== 4'b1100) $display("[TB] FAIL nominal_edge10 got %b want 1100", status); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b1010) $display("[TB] FAIL nominal_run_edge11 got %b want 1010", status); else n_pass++;
    endtask

    task automatic test_lock_loss();
        pll_locked = 1'b0;
        tick(2);
        n_checks++;
        if (status !== 4'b1010) $display("[TB] FAIL loss_edge2 got %b want 1010", status); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b0100 || loss_cnt !== 8'd1) $display("[TB] FAIL loss_edge3 got %b loss=%0d want 0100 loss=1", status, loss_cnt); else n_pass++;
        pll_locked = 1'b1;
        tick(3);
        n_checks++;
        if (status !== 4'b0100) $display("[TB] FAIL loss_prst_hold got %b want 0100", status); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b1100) $display("[TB] FAIL loss_prst_release got %b want 1100", status); else n_pass++;
        tick(8);
        n_checks++;
        if (status !== 4'b1100) $display("[TB] FAIL loss_stable_end got %b want 1100", status); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b1010 || loss_cnt !== 8'd1) $display("[TB] FAIL loss_rerun got %b loss=%0d want 1010 loss=1", status, loss_cnt); else n_pass++;
    endtask

    task automatic test_force_run();
        force_reset = 1'b1;
        tick(1);
        force_reset = 1'b0;
        n_checks++;
        if (status !== 4'b0100 || retry_cnt !== 2'd0 || loss_cnt !== 8'd1) $display("[TB] FAIL force_run got %b retry=%0d loss=%0d want 0100 0 1", status, retry_cnt, loss_cnt); else n_pass++;
        tick(12);
        n_checks++;
        if (status !== 4'b1100) $display("[TB] FAIL force_run_stable got %b want 1100", status); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b1010) $display("[TB] FAIL force_run_rerun got %b want 1010", status); else n_pass++;
    endtask

    // Lock drops at stable count 5; the synced drop lands on the final count.
    task automatic test_glitch();
        force_reset = 1'b1;
        tick(1);
        force_reset = 1'b0;
        tick(10);
        pll_locked = 1'b0;
        tick(3);
        n_checks++;
        if (status !== 4'b1100 || retry_cnt !== 2'd0) $display("[TB] FAIL glitch_wait got %b retry=%0d want 1100 0", status, retry_cnt); else n_pass++;
        pll_locked = 1'b1;
        tick(10);
        n_checks++;
        if (status !== 4'b1100) $display("[TB] FAIL glitch_prerun got %b want 1100", status); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b1010 || retry_cnt !== 2'd0) $display("[TB] FAIL glitch_run got %b retry=%0d want 1010 0", status, retry_cnt); else n_pass++;
    endtask

    task automatic test_timeout();
        int bad;
        pll_locked = 1'b0;
        tick(3);
        n_checks++;
        if (status !== 4'b0100 || loss_cnt !== 8'd2 || retry_cnt !== 2'd0) $display("[TB] FAIL to_start got %b loss=%0d retry=%0d want 0100 2 0", status, loss_cnt, retry_cnt); else n_pass++;
        tick(3);
        n_checks++;
        if (status !== 4'b0100) $display("[TB] FAIL to_prst0_hold got %b want 0100", status); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b1100) $display("[TB] FAIL to_wait0 got %b want 1100", status); else n_pass++;
        tick(31);
        n_checks++;
        if (status !== 4'b1100 || retry_cnt !== 2'd0) $display("[TB] FAIL to_wait0_end got %b retry=%0d want 1100 0", status, retry_cnt); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b0100 || retry_cnt !== 2'd1) $display("[TB] FAIL to_retry1 got %b retry=%0d want 0100 1", status, retry_cnt); else n_pass++;
        tick(3);
        n_checks++;
        if (status !== 4'b0100) $display("[TB] FAIL to_prst1_hold got %b want 0100", status); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b1100) $display("[TB] FAIL to_wait1 got %b want 1100", status); else n_pass++;
        tick(31);
        n_checks++;
        if (status !== 4'b1100 || retry_cnt !== 2'd1) $display("[TB] FAIL to_wait1_end got %b retry=%0d want 1100 1", status, retry_cnt); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b0100 || retry_cnt !== 2'd2) $display("[TB] FAIL to_retry2 got %b retry=%0d want 0100 2", status, retry_cnt); else n_pass++;
        tick(4);
        n_checks++;
        if (status !== 4'b1100) $display("[TB] FAIL to_wait2 got %b want 1100", status); else n_pass++;
        tick(31);
        n_checks++;
        if (status !== 4'b1100) $display("[TB] FAIL to_wait2_end got %b want 1100", status); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b0101 || retry_cnt !== 2'd2) $display("[TB] FAIL to_fail got %b retry=%0d want 0101 2", status, retry_cnt); else n_pass++;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (status !== 4'b0101) bad++;
        end
        n_checks++;
        if (bad != 0) $display("[TB] FAIL fail_sticky got %0d bad cycles want 0 (last %b)", bad, status); else n_pass++;
    endtask

    task automatic test_force_fail();
        force_reset = 1'b1;
        tick(1);
        force_reset = 1'b0;
        n_checks++;
        if (status !== 4'b0100 || retry_cnt !== 2'd0 || loss_cnt !== 8'd2) $display("[TB] FAIL force_fail got %b retry=%0d loss=%0d want 0100 0 2", status, retry_cnt, loss_cnt); else n_pass++;
    endtask

    task automatic test_loss_saturation();
        int exp_loss;
        pll_locked = 1'b1;
        tick(13);
        n_checks++;
        if (status !== 4'b1010) $display("[TB] FAIL sat_first_run got %b want 1010", status); else n_pass++;
        for (int i = 0; i < 300; i++) begin
            exp_loss = (3 + i > 255) ? 255 : 3 + i;
            pll_locked = 1'b0;
            tick(3);
            n_checks++;
            if (status !== 4'b0100 || loss_cnt !== exp_loss[7:0]) $display("[TB] FAIL sat_loss_%0d got %b loss=%0d want 0100 loss=%0d", i, status, loss_cnt, exp_loss); else n_pass++;
            pll_locked = 1'b1;
            tick(13);
            n_checks++;
            if (status !== 4'b1010) $display("[TB] FAIL sat_rerun_%0d got %b want 1010", i, status); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        force_reset = 1'b1;
        tick(1);
        force_reset = 1'b0;
        tick(7);
        n_checks++;
        if (status !== 4'b1100 || loss_cnt !== 8'd255) $display("[TB] FAIL async_pre got %b loss=%0d want 1100 255", status, loss_cnt); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (status !== 4'b0100 || retry_cnt !== 2'd0 || loss_cnt !== 8'd0) $display("[TB] FAIL async_rst got %b retry=%0d loss=%0d want 0100 0 0", status, retry_cnt, loss_cnt); else n_pass++;
        #1;
        rst = 1'b0;
        tick(12);
        n_checks++;
        if (status !== 4'b1100) $display("[TB] FAIL async_post_stable got %b want 1100", status); else n_pass++;
        tick(1);
        n_checks++;
        if (status !== 4'b1010) $display("[TB] FAIL async_post_run got %b want 1010", status); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_loss();
        test_force_run();
        test_glitch();
        test_timeout();
        test_force_fail();
        test_loss_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
